n64_rcp_pif_initiator: RTL and testbench
========================================

Name: n64_rcp_pif_initiator

Overview:
- Serial-bus master: the RCP side of the one-wire RCP<->PIF link. Issues PIF RAM/ROM read and write requests and moves 4- or 64-byte payloads.
- Used as the bring-up/loopback partner for the PIF responder, and as the host-driven bus exerciser on the FPGA test build.
- Host side is parallel: command handshake, per-word write-data fetch, per-word read-data strobes.

Parameters:
- ACK_TIMEOUT, 1023, max clk cycles spent waiting for the PIF ack low before aborting (10-bit counter range).
- SYNC_STAGES, 2, flops on pif_in before any use (2..3).

Ports:
- clk  in  1  link clock (n64_clk domain); all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_type  in  2  0=read4, 1=read64, 2=write4, 3=write64.
- cmd_addr  in  9  PIF word address.
- wr_data_req  out  1  one-cycle pulse requesting the next write word.
- wr_word_idx  out  4  index of the requested word (0..15).
- wr_data  in  32  write word, sampled exactly 1 cycle after wr_data_req.
- rd_valid  out  1  one-cycle pulse: rd_data holds a complete word.
- rd_data  out  32  received word.
- rd_word_idx  out  4  index of rd_data.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on ack timeout.
- busy  out  1  high whenever state != IDLE.
- rsp_out  out  1  serial line to PIF; idles high.
- pif_in  in  1  serial line from PIF; idles high.

Behaviour:
- Reset values: rsp_out=1, all other outputs 0 (cmd_ready=1 once IDLE is entered), state=IDLE, counters 0. Reset aborts any transfer in the cycle it is sampled; rsp_out returns high on the next edge.
- Input path: pif_in passes through SYNC_STAGES flops, giving pif_s. Edge detect is pif_s==0 with its previous value ==1.
- IDLE: on cmd_valid&&cmd_ready, latch type/addr, then go to START. For write types, also pulse wr_data_req with idx 0 in the same cycle.
- START: rsp_out=0 for exactly 1 cycle, then ADDR.
- ADDR: shift 11 bits MSB-first, {type[1:0],addr[8:0]}, one bit per cycle (11 cycles). Then WAIT_ACK with rsp_out=1.
- WAIT_ACK: wait for the falling edge on pif_s. For reads, go to RD_DATA. For writes, go to WR_ACK.
- WR_ACK: rsp_out=0 for 1 cycle, then WR_DATA.
- WR_DATA: send 32 (write4) or 512 (write64) bits, MSB of each word first, one per cycle.
  - The next word is requested when 2 bits of the current word remain. That word is captured into a holding register 1 cycle later and loaded into the shift register on the cycle after the current word's last bit.
  - No request is issued after the final word.
  - After the last bit: rsp_out=1, then DONE.
- RD_DATA: the first data bit is the pif_s sample on the cycle after the ack edge. Shift 32 or 512 bits MSB-first.
  - Each completed 32 bits: rd_valid pulses with rd_data, and rd_word_idx increments (0..15).
  - After the last word: DONE.
- DONE: done=1 for 1 cycle, then IDLE.
- cmd_valid in any state except IDLE is ignored; no queuing.
- Bit counter is 10 bits wide, and the word index wraps only via reset/new command.
- Address bits beyond 9 are not generated. The PIF advances the address for 64-byte transfers; the initiator does not resend it.

Optional Feature:
- Macro RCP_PIF_ACK_TIMEOUT_EN.
- Defined: a 10-bit counter runs in WAIT_ACK. When it reaches ACK_TIMEOUT with no ack edge: error=1 for 1 cycle, rsp_out=1, return to IDLE, no done pulse. The counter clears on WAIT_ACK entry.
- Undefined: WAIT_ACK waits indefinitely, error is tied to 0, and no counter logic is present.

Test Plan:
- read4 addr 0x1F0, PIF model acks then returns 0xDEADBEEF -> rsp_out sequence 0, then bits 00_111110000. One rd_valid with rd_data=0xDEADBEEF and idx 0, then done, 32 data cycles after the ack.
- write4 addr 0x010, host supplies 0x12345678 -> after the PIF ack, rsp_out pulses low 1 cycle, then serialises 0x12345678 MSB-first. Exactly one wr_data_req (idx 0); done follows the final bit.
- read64 addr 0x1F0, model streams words 0x00000000..0x0000000F -> 16 rd_valid pulses, idx 0..15 matching data, 512 bit cycles, a single done.
- write64, host returns word = idx*0x01010101 -> 16 wr_data_req pulses, idx 0..15, each 30 cycles into the previous word. The line carries an unbroken 512-bit stream with no gaps.
- With RCP_PIF_ACK_TIMEOUT_EN and ACK_TIMEOUT=20, PIF never acks -> error pulse exactly 20 cycles after WAIT_ACK entry, rsp_out=1, cmd_ready=1, no done.
- Assert reset during read64 word 5 -> next cycle rsp_out=1, busy=0, no further rd_valid. A following read4 completes normally.

Source files
------------

// File: rtl/n64_rcp_pif_initiator_if.sv
// Host-side parallel interface of the RCP->PIF serial initiator.
// Carries the command handshake, the per-word write-data fetch and the
// per-word read-data strobes, plus the done/error/busy status pulses.
//   master : host side (issues commands, supplies write words)
//   slave  : initiator side (n64_rcp_pif_initiator)
interface n64_rcp_pif_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [8:0]  cmd_addr;
  logic        wr_data_req;
  logic [3:0]  wr_word_idx;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  rd_word_idx;
  logic        done;
  logic        error;
  logic        busy;

  modport master (
    output cmd_valid, cmd_type, cmd_addr, wr_data,
    input  cmd_ready, wr_data_req, wr_word_idx, rd_valid, rd_data,
           rd_word_idx, done, error, busy
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, wr_data,
    output cmd_ready, wr_data_req, wr_word_idx, rd_valid, rd_data,
           rd_word_idx, done, error, busy
  );
endinterface

// File: rtl/n64_rcp_pif_initiator.sv
// RCP side of the one-wire RCP<->PIF link: serial bus master issuing PIF
// RAM/ROM read4/read64/write4/write64 requests.
// Ports:
//   clk     link clock, all logic on posedge
//   reset   synchronous active-high reset
//   host    n64_rcp_pif_initiator_if.slave (command / data / status)
//   rsp_out serial line to PIF, idles high
//   pif_in  serial line from PIF, idles high
// Optional build macro RCP_PIF_ACK_TIMEOUT_EN: abort with an error pulse
// when the PIF ack has not arrived within ACK_TIMEOUT cycles of WAIT_ACK.
module n64_rcp_pif_initiator #(
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  n64_rcp_pif_initiator_if.slave       host,
  output logic                         rsp_out,
  input  logic                         pif_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_WAIT_ACK, S_WR_ACK, S_WR_DATA, S_RD_DATA, S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic        pif_s, pif_prev, ack_edge;
  logic [1:0]  type_q;
  logic [31:0] sr;          // shared shift register: address, write or read bits
  logic [31:0] hold;
  logic [9:0]  cnt;
  logic [9:0]  cnt_last;
  logic [3:0]  last_word;
  logic        req_d;
  logic        req;
  logic [3:0]  req_idx;
  logic        err;
  logic        rd_valid_q;
  logic [31:0] rd_data_q;
  logic [3:0]  rd_idx_q;

  assign pif_s     = sync_q[SYNC_STAGES-1];
  assign ack_edge  = !pif_s && pif_prev;
  assign cnt_last  = type_q[0] ? 10'd511 : 10'd31;
  assign last_word = type_q[0] ? 4'd15 : 4'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '1;
      pif_prev <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pif_in};
      pif_prev <= pif_s;
    end
  end

`ifdef RCP_PIF_ACK_TIMEOUT_EN
  logic [9:0] to_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != S_WAIT_ACK) to_cnt <= '0;
    else                              to_cnt <= to_cnt + 10'd1;
  end
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = ^ACK_TIMEOUT;
`endif

  always_comb begin
    state_nx = state;
    rsp_out  = 1'b1;
    req      = 1'b0;
    req_idx  = '0;
    err      = 1'b0;
    case (state)
      S_IDLE: begin
        if (host.cmd_valid) begin
          state_nx = S_START;
          req      = host.cmd_type[1];
        end
      end
      S_START: begin
        rsp_out  = 1'b0;
        state_nx = S_ADDR;
      end
      S_ADDR: begin
        rsp_out = sr[31];
        if (cnt == 10'd10) state_nx = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_edge) state_nx = type_q[1] ? S_WR_ACK : S_RD_DATA;
`ifdef RCP_PIF_ACK_TIMEOUT_EN
        else if (to_cnt == ACK_TIMEOUT[9:0]) begin
          err      = 1'b1;
          state_nx = S_IDLE;
        end
`endif
      end
      S_WR_ACK: begin
        rsp_out  = 1'b0;
        state_nx = S_WR_DATA;
      end
      S_WR_DATA: begin
        rsp_out = sr[31];
        // Fetch the next word two bits early so it is in hand for the boundary.
        if (cnt[4:0] == 5'd30 && cnt[8:5] != last_word) begin
          req     = 1'b1;
          req_idx = cnt[8:5] + 4'd1;
        end
        if (cnt == cnt_last) state_nx = S_DONE;
      end
      S_RD_DATA: begin
        if (cnt == cnt_last) state_nx = S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      type_q     <= '0;
      sr         <= '0;
      hold       <= '0;
      cnt        <= '0;
      req_d      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
    end else begin
      state      <= state_nx;
      req_d      <= req;
      rd_valid_q <= 1'b0;
      if (req_d) hold <= host.wr_data;
      case (state)
        S_IDLE: begin
          if (host.cmd_valid) begin
            type_q <= host.cmd_type;
            sr     <= {host.cmd_type, host.cmd_addr, 21'd0};
            cnt    <= '0;
          end
        end
        S_ADDR: begin
          sr  <= {sr[30:0], 1'b0};
          cnt <= cnt + 10'd1;
        end
        S_WAIT_ACK: cnt <= '0;
        S_WR_ACK: begin
          sr  <= hold;
          cnt <= '0;
        end
        S_WR_DATA: begin
          cnt <= cnt + 10'd1;
          // Words after the first bypass the holding register so the line
          // carries no gap at word boundaries.
          if (req_d) sr <= host.wr_data;
          else       sr <= {sr[30:0], 1'b0};
        end
        S_RD_DATA: begin
          sr  <= {sr[30:0], pif_s};
          cnt <= cnt + 10'd1;
          if (cnt[4:0] == 5'd31) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= {sr[30:0], pif_s};
            rd_idx_q   <= cnt[8:5];
          end
        end
        S_DONE: cnt <= '0;
        default: ;
      endcase
    end
  end

  assign host.cmd_ready   = (state == S_IDLE);
  assign host.busy        = (state != S_IDLE);
  assign host.done        = (state == S_DONE);
  assign host.error       = err;
  assign host.wr_data_req = req;
  assign host.wr_word_idx = req_idx;
  assign host.rd_valid    = rd_valid_q;
  assign host.rd_data     = rd_data_q;
  assign host.rd_word_idx = rd_idx_q;

endmodule

// File: tb/tb_n64_rcp_pif_initiator.sv
`timescale 1ns/1ps
module tb_n64_rcp_pif_initiator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rsp_out;
  logic pif_in = 1'b1;

  n64_rcp_pif_initiator_if bus ();

  n64_rcp_pif_initiator #(.ACK_TIMEOUT(20), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .host(bus.slave), .rsp_out(rsp_out), .pif_in(pif_in)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] txn_words [16];

  typedef struct {
    logic [1:0] typ;
    logic [8:0] addr;
    int         delay;
    int         pat;
    int         exp_done;
    int         exp_pulses;
  } vec_t;

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic stream_bit(input int i);
    logic [31:0] w;
    w = txn_words[i / 32];
    return w[31 - (i % 32)];
  endfunction

  // PIF line model: ack low for one slot at cycle k, read payload right after.
  function automatic logic pif_drive(input int n, input bit rd, input int k, input int nbits);
    if (n == k) return 1'b0;
    if (rd && n > k && n <= k + nbits) return stream_bit(n - k - 1);
    return 1'b1;
  endfunction

  task automatic fill_words(input int pat);
    for (int j = 0; j < 16; j++) begin
      case (pat)
        0: txn_words[j] = 32'hDEADBEEF;
        1: txn_words[j] = 32'h12345678;
        2: txn_words[j] = 32'(j);
        3: txn_words[j] = 32'(j) * 32'h01010101;
        default: txn_words[j] = $urandom;
      endcase
    end
  endtask

  // Cycle 0 = command accepted; START=1, ADDR=2..12, WAIT_ACK from 13.
  task automatic run_txn(input logic [1:0] typ, input logic [8:0] addr, input int delay,
                         input bit hold_valid, output int done_cyc, output int pulses);
    int nw, nbits, k, w, e, rd_word, req_word;
    bit rd, busy_e, req_seen;
    logic [10:0] aw;
    logic e_rsp, e_rdv, e_req;
    logic [3:0] req_idx;
    nw = typ[0] ? 16 : 1;
    nbits = 32 * nw;
    rd = !typ[1];
    k = 11 + delay;
    w = 13 + delay;
    e = rd ? w + nbits + 1 : w + 2 + nbits;
    aw = {typ, addr};
    done_cyc = -1;
    pulses = 0;
    req_seen = 0;
    req_idx = '0;
    for (int n = 0; n <= e + 2; n++) begin
      @(posedge clk); #1;
      bus.cmd_valid = (n == 0) || (hold_valid && n <= e);
      bus.cmd_type  = (n == 0) ? typ : 2'($urandom);
      bus.cmd_addr  = (n == 0) ? addr : 9'($urandom);
      bus.wr_data   = req_seen ? txn_words[req_idx] : $urandom;
      pif_in = pif_drive(n, rd, k, nbits);
      @(negedge clk);
      e_rsp = 1'b1;
      if (n == 1) e_rsp = 1'b0;
      else if (n >= 2 && n <= 12) e_rsp = aw[12 - n];
      else if (!rd && n == w + 1) e_rsp = 1'b0;
      else if (!rd && n >= w + 2 && n <= w + 1 + nbits) e_rsp = stream_bit(n - w - 2);
      e_rdv = 1'b0; rd_word = 0;
      if (rd && n >= w + 33 && (n - w - 33) % 32 == 0 && n <= e) begin
        e_rdv = 1'b1; rd_word = (n - w - 33) / 32;
      end
      e_req = 1'b0; req_word = 0;
      if (!rd && n == 0) e_req = 1'b1;
      else if (!rd && n >= w + 32 && (n - w) % 32 == 0 && (n - w) / 32 <= nw - 1) begin
        e_req = 1'b1; req_word = (n - w) / 32;
      end
      busy_e = (n >= 1 && n <= e);
      check("rsp_out", n, 32'(rsp_out), 32'(e_rsp));
      check("busy", n, 32'(bus.busy), 32'(busy_e));
      check("cmd_ready", n, 32'(bus.cmd_ready), 32'(!busy_e));
      check("done", n, 32'(bus.done), 32'(n == e));
      check("error", n, 32'(bus.error), 32'd0);
      check("rd_valid", n, 32'(bus.rd_valid), 32'(e_rdv));
      check("wr_data_req", n, 32'(bus.wr_data_req), 32'(e_req));
      if (e_rdv) begin
        check("rd_data", n, bus.rd_data, txn_words[rd_word]);
        check("rd_word_idx", n, 32'(bus.rd_word_idx), 32'(rd_word));
      end
      if (e_req) check("wr_word_idx", n, 32'(bus.wr_word_idx), 32'(req_word));
      req_seen = bus.wr_data_req;
      req_idx  = bus.wr_word_idx;
      if (bus.done && done_cyc < 0) done_cyc = n;
      if (rd ? bus.rd_valid : bus.wr_data_req) pulses++;
    end
    bus.cmd_valid = 1'b0;
  endtask

  vec_t vecs [5];
  int dc, pc;

  initial begin
    vecs[0] = '{2'd0, 9'h1F0, 0, 0, 46, 1};
    vecs[1] = '{2'd2, 9'h010, 0, 1, 47, 1};
    vecs[2] = '{2'd1, 9'h1F0, 0, 2, 526, 16};
    vecs[3] = '{2'd3, 9'h0AA, 0, 3, 527, 16};
    vecs[4] = '{2'd0, 9'h155, 3, 0, 49, 1};

    bus.cmd_valid = 1'b0;
    bus.cmd_type  = '0;
    bus.cmd_addr  = '0;
    bus.wr_data   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_out", 0, 32'(rsp_out), 32'd1);
    check("rst_busy", 0, 32'(bus.busy), 32'd0);
    check("rst_cmd_ready", 0, 32'(bus.cmd_ready), 32'd1);
    check("rst_done", 0, 32'(bus.done), 32'd0);
    check("rst_error", 0, 32'(bus.error), 32'd0);
    check("rst_rd_valid", 0, 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 0, bus.rd_data, 32'd0);
    check("rst_wr_data_req", 0, 32'(bus.wr_data_req), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Test-plan transactions
    foreach (vecs[i]) begin
      fill_words(vecs[i].pat);
      run_txn(vecs[i].typ, vecs[i].addr, vecs[i].delay, 1'b0, dc, pc);
      check("done_cycle", i, 32'(dc), 32'(vecs[i].exp_done));
      check("pulse_count", i, 32'(pc), 32'(vecs[i].exp_pulses));
    end

`ifdef RCP_PIF_ACK_TIMEOUT_EN
    // No ack: error 20 cycles after WAIT_ACK entry (cycle 13), no done.
    for (int n = 0; n <= 40; n++) begin
      logic [10:0] aw;
      logic e_rsp;
      aw = {2'd0, 9'h055};
      @(posedge clk); #1;
      bus.cmd_valid = (n == 0);
      bus.cmd_type  = 2'd0;
      bus.cmd_addr  = 9'h055;
      pif_in = 1'b1;
      @(negedge clk);
      e_rsp = 1'b1;
      if (n == 1) e_rsp = 1'b0;
      else if (n >= 2 && n <= 12) e_rsp = aw[12 - n];
      check("to_error", n, 32'(bus.error), 32'(n == 33));
      check("to_busy", n, 32'(bus.busy), 32'(n >= 1 && n <= 33));
      check("to_cmd_ready", n, 32'(bus.cmd_ready), 32'(n == 0 || n >= 34));
      check("to_done", n, 32'(bus.done), 32'd0);
      check("to_rsp_out", n, 32'(rsp_out), 32'(e_rsp));
    end
    bus.cmd_valid = 1'b0;
`endif

    // Reset during word 5 of a read64 (ack edge at 13, word 5 bits from 174)
    fill_words(2);
    for (int n = 0; n <= 600; n++) begin
      bit e_rdv;
      @(posedge clk); #1;
      bus.cmd_valid = (n == 0);
      bus.cmd_type  = 2'd1;
      bus.cmd_addr  = 9'h1F0;
      reset  = (n == 184);
      pif_in = pif_drive(n, 1'b1, 11, 512);
      @(negedge clk);
      e_rdv = (n < 184 && n >= 46 && (n - 46) % 32 == 0);
      check("rst64_rd_valid", n, 32'(bus.rd_valid), 32'(e_rdv));
      if (e_rdv) check("rst64_rd_data", n, bus.rd_data, 32'((n - 46) / 32));
      if (n == 185) check("rst64_rsp_out", n, 32'(rsp_out), 32'd1);
      if (n >= 185) check("rst64_busy", n, 32'(bus.busy), 32'd0);
    end
    fill_words(0);
    run_txn(2'd0, 9'h1F0, 0, 1'b0, dc, pc);
    check("post_rst_done_cycle", 0, 32'(dc), 32'd46);
    check("post_rst_pulses", 0, 32'(pc), 32'd1);

    // Randomized transactions against the timeline model
    for (int t = 0; t < 30; t++) begin
      logic [1:0] typ;
      int d;
      typ = 2'($urandom);
      d = $urandom_range(0, 6);
      fill_words(9);
      run_txn(typ, 9'($urandom), d, 1'($urandom), dc, pc);
      check("rnd_pulses", t, 32'(pc), typ[0] ? 32'd16 : 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
